cnn_layer_seq: RTL

Top-level layer scheduler for the CNN accelerator. It launches the layer engines in a fixed order: CONV1, MP1, CONV2, MP2, FC. It waits for each engine's end flag, hands ownership of the shared feature-map RAM port to the active engine, and reports overall completion or a watchdog timeout to the host.

---
 rtl/cnn_layer_seq_pkg.sv | 25 ++
 rtl/cnn_layer_seq_if.sv | 36 +++
 rtl/cnn_layer_seq_watchdog.sv | 31 +++
 rtl/cnn_layer_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cnn_layer_seq_pkg.sv
// Shared constants and types for the CNN layer scheduler: layer launch
// indices, the "no owner" RAM select code and the scheduler state encoding.
package cnn_pkg;

    // Launch order of the layer engines
    localparam logic [2:0] L_CONV1 = 3'd0;
    localparam logic [2:0] L_MP1   = 3'd1;
    localparam logic [2:0] L_CONV2 = 3'd2;
    localparam logic [2:0] L_MP2   = 3'd3;
    localparam logic [2:0] L_FC    = 3'd4;

    // Shared feature-map RAM port owned by nobody
    localparam logic [2:0] RAM_SEL_NONE = 3'd7;

    // Scheduler state encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_WAIT = 3'd2,
        ST_GAP  = 3'd3,
        ST_FIN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/cnn_layer_seq_if.sv
// Host/engine-facing signal bundle of the layer scheduler.
//
// Handshake: start is a host request sampled only while the scheduler is
// idle. Toward each engine, layer_start[i] is a level held high until the
// scheduler samples layer_end[i] high; layer_start then drops on the next
// edge. layer_end[i] is a level the engine keeps high until it is idle
// again, and the scheduler waits for it to fall before the next launch.
// dbg_state mirrors the scheduler state for observation only.
interface cnn_layer_seq_if #(
    parameter int N_LAYERS = 5
);
    import cnn_pkg::*;

    logic                start;
    logic                abort;
    logic [N_LAYERS-1:0] layer_en;
    logic [N_LAYERS-1:0] layer_end;
    logic [N_LAYERS-1:0] layer_start;
    logic [2:0]          ram_sel;
    logic [2:0]          cur_layer;
    logic                busy;
    logic                done;
    logic                err;
    state_t              dbg_state;

    modport master (
        output start, abort, layer_en, layer_end,
        input  layer_start, ram_sel, cur_layer, busy, done, err, dbg_state
    );

    modport slave (
        input  start, abort, layer_en, layer_end,
        output layer_start, ram_sel, cur_layer, busy, done, err, dbg_state
    );

endinterface

// File: rtl/cnn_layer_seq_watchdog.sv
// Watchdog counter for the layer scheduler: counts enabled cycles since the
// last clear and flags when the limit is reached. Holds at the limit.
module cnn_watchdog #(
    parameter int              TO_W        = 20,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 20'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] r_cnt;
    logic            w_at_limit;

    assign w_at_limit = (r_cnt == TIMEOUT_CYC - TO_W'(1));
    assign expired    = w_at_limit;

    // Count enabled cycles; clear wins, saturate so the flag cannot wrap away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !w_at_limit) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/cnn_layer_seq.sv
// Layer scheduler: launches the enabled layer engines in fixed order, hands
// the shared RAM port to the active engine, enforces an idle gap between
// layers and reports completion or a watchdog timeout to the host.
module cnn_layer_seq
    import cnn_pkg::*;
#(
    parameter int              N_LAYERS    = 5,
    parameter int              TO_W        = 20,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 20'd1000000,
    parameter int              GAP_CYC     = 4
) (
    input logic            clk,
    input logic            rst_n,
    cnn_layer_seq_if.slave bus
);

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_idx;
    logic [N_LAYERS-1:0] r_en_q;
    logic [7:0]          r_gap_cnt;
    logic [2:0]          r_cur_layer;
    logic                r_err;

    logic w_idx_end;
    logic w_en_cur;
    logic w_end_cur;
    logic w_gap_done;
    logic w_launch;
    logic w_expired;

    assign w_idx_end  = (r_idx == 3'(N_LAYERS));
    assign w_gap_done = (r_gap_cnt >= 8'(GAP_CYC - 1));
    assign w_launch   = (r_state == ST_SCAN) && !w_idx_end && w_en_cur;

    // Select the enable and end flag of the layer at the current index
    always_comb begin
        w_en_cur  = 1'b0;
        w_end_cur = 1'b0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (r_idx == 3'(i)) begin
                w_en_cur  = r_en_q[i];
                w_end_cur = bus.layer_end[i];
            end
        end
    end

    cnn_watchdog #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (r_state == ST_SCAN),
        .en      (r_state == ST_WAIT),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; abort overrides everything, completion beats the watchdog
    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.start) w_next = ST_SCAN;
                ST_SCAN: begin
                    if (w_idx_end)     w_next = ST_FIN;
                    else if (w_en_cur) w_next = ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_end_cur)      w_next = ST_GAP;
                    else if (w_expired) w_next = ST_ERR;
                end
                ST_GAP:  if (w_gap_done && !w_end_cur) w_next = ST_SCAN;
                ST_FIN:  w_next = ST_IDLE;
                ST_ERR:  w_next = ST_IDLE;
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Layer index, latched enables, gap counter, last launched layer, error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= L_CONV1;
            r_en_q      <= '0;
            r_gap_cnt   <= '0;
            r_cur_layer <= L_CONV1;
            r_err       <= 1'b0;
        end else if (bus.abort) begin
            r_idx       <= L_CONV1;
            r_gap_cnt   <= '0;
            r_cur_layer <= L_CONV1;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_en_q <= bus.layer_en;
                        r_idx  <= L_CONV1;
                        r_err  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_gap_cnt <= '0;
                    if (w_launch)        r_cur_layer <= r_idx;
                    else if (!w_idx_end) r_idx       <= r_idx + 3'd1;
                end
                ST_WAIT: begin
                    if (!w_end_cur && w_expired) r_err <= 1'b1;
                end
                ST_GAP: begin
                    if (!w_gap_done)     r_gap_cnt <= r_gap_cnt + 8'd1;
                    else if (!w_end_cur) r_idx     <= r_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from state; RAM stays owned through GAP
    always_comb begin
        bus.layer_start = '0;
        bus.ram_sel     = RAM_SEL_NONE;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        case (r_state)
            ST_SCAN: bus.busy = 1'b1;
            ST_WAIT: begin
                bus.busy    = 1'b1;
                bus.ram_sel = r_idx;
                for (int i = 0; i < N_LAYERS; i++) begin
                    bus.layer_start[i] = (r_idx == 3'(i));
                end
            end
            ST_GAP: begin
                bus.busy    = 1'b1;
                bus.ram_sel = r_idx;
            end
            ST_FIN:  bus.done = 1'b1;
            default: ;
        endcase
    end

    assign bus.cur_layer = r_cur_layer;
    assign bus.err       = r_err;
    assign bus.dbg_state = r_state;

endmodule
